// File: rtl/logic_ex_stage.sv
// Execute stage for the 32-bit bitwise unit: computes the op result and queues it in a
// 2-entry skid buffer. Optional LOGIC_EX_PARITY_EN adds a per-result parity output.
module logic_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_data_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_zero_o
`ifdef LOGIC_EX_PARITY_EN
    ,
    output logic             out_parity_o
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e           r_state_q;
    state_e           w_state_d;
    logic             r_in_ready_q;

    logic [XLEN-1:0]  r_h_data_q;
    logic [TAG_W-1:0] r_h_tag_q;
    logic             r_h_zero_q;
    logic [XLEN-1:0]  r_s_data_q;
    logic [TAG_W-1:0] r_s_tag_q;
    logic             r_s_zero_q;
`ifdef LOGIC_EX_PARITY_EN
    logic             r_h_par_q;
    logic             r_s_par_q;
    logic             w_par;
`endif

    logic [XLEN-1:0]  w_res;
    logic             w_zero;
    logic             w_push;
    logic             w_pop;
    logic             w_load_h_new;
    logic             w_load_h_skid;
    logic             w_load_s;

    always_comb begin
        w_res = '0;
        unique case (op_i)
            3'b000: w_res = a_i | b_i;
            3'b001: w_res = a_i & b_i;
            3'b010: w_res = a_i ^ b_i;
            3'b011: w_res = ~(a_i | b_i);
            3'b100: w_res = a_i & ~b_i;
            3'b101: w_res = a_i | ~b_i;
            3'b110: w_res = ~(a_i ^ b_i);
            3'b111: w_res = b_i;
            default: w_res = '0;
        endcase
    end

    assign w_zero = (w_res == '0);
`ifdef LOGIC_EX_PARITY_EN
    assign w_par  = ^w_res;
`endif

    assign w_push = in_valid_i & r_in_ready_q;
    assign w_pop  = out_valid_o & out_ready_i;

    always_comb begin
        w_state_d     = r_state_q;
        w_load_h_new  = 1'b0;
        w_load_h_skid = 1'b0;
        w_load_s      = 1'b0;
        if (flush_i) begin
            w_state_d = StEmpty;
        end else begin
            case (r_state_q)
                StEmpty: begin
                    if (w_push) begin
                        w_state_d    = StOne;
                        w_load_h_new = 1'b1;
                    end
                end
                StOne: begin
                    if (w_push && w_pop) begin
                        w_load_h_new = 1'b1;
                    end else if (w_push) begin
                        w_state_d = StTwo;
                        w_load_s  = 1'b1;
                    end else if (w_pop) begin
                        w_state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only a pop can happen
                    if (w_pop) begin
                        w_state_d     = StOne;
                        w_load_h_skid = 1'b1;
                    end
                end
                default: w_state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q    <= StEmpty;
            r_in_ready_q <= 1'b1;
            r_h_data_q   <= '0;
            r_h_tag_q    <= '0;
            r_h_zero_q   <= 1'b1;
            r_s_data_q   <= '0;
            r_s_tag_q    <= '0;
            r_s_zero_q   <= 1'b1;
`ifdef LOGIC_EX_PARITY_EN
            r_h_par_q    <= 1'b0;
            r_s_par_q    <= 1'b0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_in_ready_q <= (w_state_d != StTwo);
            if (w_load_h_new) begin
                r_h_data_q <= w_res;
                r_h_tag_q  <= tag_i;
                r_h_zero_q <= w_zero;
`ifdef LOGIC_EX_PARITY_EN
                r_h_par_q  <= w_par;
`endif
            end else if (w_load_h_skid) begin
                r_h_data_q <= r_s_data_q;
                r_h_tag_q  <= r_s_tag_q;
                r_h_zero_q <= r_s_zero_q;
`ifdef LOGIC_EX_PARITY_EN
                r_h_par_q  <= r_s_par_q;
`endif
            end
            if (w_load_s) begin
                r_s_data_q <= w_res;
                r_s_tag_q  <= tag_i;
                r_s_zero_q <= w_zero;
`ifdef LOGIC_EX_PARITY_EN
                r_s_par_q  <= w_par;
`endif
            end
        end
    end

    assign in_ready_o  = r_in_ready_q;
    assign out_valid_o = (r_state_q != StEmpty);
    assign out_data_o  = r_h_data_q;
    assign out_tag_o   = r_h_tag_q;
    assign out_zero_o  = r_h_zero_q;
`ifdef LOGIC_EX_PARITY_EN
    assign out_parity_o = r_h_par_q;
`endif

endmodule

// File: tb/tb_logic_ex_stage.sv
// Directed-vector bench for logic_ex_stage: reset, op sweep, backpressure, zero, flush, reset.
module tb_logic_ex_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_zero;
`ifdef LOGIC_EX_PARITY_EN
    logic        out_parity;
`endif

    int n_cmp;
    int n_err;

    logic [31:0] exp_ops [8];

    logic_ex_stage #(
        .XLEN  (32),
        .TAG_W (5)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_tag_o   (out_tag),
        .out_zero_o  (out_zero)
`ifdef LOGIC_EX_PARITY_EN
        ,
        .out_parity_o (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_ops[0] = 32'hFFFF_FF00;
        exp_ops[1] = 32'hFF00_0000;
        exp_ops[2] = 32'h00FF_FF00;
        exp_ops[3] = 32'h0000_00FF;
        exp_ops[4] = 32'h00FF_0000;
        exp_ops[5] = 32'hFFFF_00FF;
        exp_ops[6] = 32'hFF00_00FF;
        exp_ops[7] = 32'hFF00_FF00;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; a = '0; b = '0; tag = '0;
        step();
        step();
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_data", out_data, 32'd0);
        check_eq("rst_tag", {27'd0, out_tag}, 32'd0);
        check_eq("rst_zero", {31'd0, out_zero}, 32'd1);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
`ifdef LOGIC_EX_PARITY_EN
        check_eq("rst_parity", {31'd0, out_parity}, 32'd0);
`endif
        rst = 1'b0;
        step();

        // Basic OR
        in_valid = 1'b1; a = 32'h0F0F_0000; b = 32'h0000_F0F0; op = 3'b000; tag = 5'd3;
        step();
        in_valid = 1'b0;
        check_eq("or_valid", {31'd0, out_valid}, 32'd1);
        check_eq("or_data", out_data, 32'h0F0F_F0F0);
        check_eq("or_tag", {27'd0, out_tag}, 32'd3);
        check_eq("or_zero", {31'd0, out_zero}, 32'd0);
        step();
        check_eq("or_drain", {31'd0, out_valid}, 32'd0);

        // Op sweep, one result per cycle with simultaneous push/pop
        a = 32'hFFFF_0000; b = 32'hFF00_FF00;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; op = 3'(i); tag = 5'(i + 8);
            step();
            check_eq($sformatf("op%0d_data", i), out_data, exp_ops[i]);
            check_eq($sformatf("op%0d_tag", i), {27'd0, out_tag}, 32'(i + 8));
            check_eq($sformatf("op%0d_ready", i), {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        check_eq("sweep_drain", {31'd0, out_valid}, 32'd0);

        // Backpressure: tags 1,2 accepted, 3 held until space frees
        out_ready = 1'b0;
        in_valid = 1'b1; a = 32'd1; b = 32'd0; op = 3'b000; tag = 5'd1;
        step();
        check_eq("bp_ready1", {31'd0, in_ready}, 32'd1);
        tag = 5'd2; a = 32'd2;
        step();
        check_eq("bp_ready2", {31'd0, in_ready}, 32'd0);
        check_eq("bp_head1", {27'd0, out_tag}, 32'd1);
        tag = 5'd3; a = 32'd3;
        step();
        check_eq("bp_hold_tag", {27'd0, out_tag}, 32'd1);
        check_eq("bp_hold_data", out_data, 32'd1);
        check_eq("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        check_eq("bp_out2", {27'd0, out_tag}, 32'd2);
        check_eq("bp_out2_data", out_data, 32'd2);
        check_eq("bp_ready3", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("bp_out3", {27'd0, out_tag}, 32'd3);
        check_eq("bp_out3_data", out_data, 32'd3);
        step();
        check_eq("bp_empty", {31'd0, out_valid}, 32'd0);

        // Zero result, then fill to TWO and flush
        out_ready = 1'b0;
        in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1234_5678; op = 3'b010; tag = 5'd7;
        step();
        check_eq("zero_data", out_data, 32'd0);
        check_eq("zero_flag", {31'd0, out_zero}, 32'd1);
        a = 32'd5; b = 32'd0; op = 3'b000; tag = 5'd8;
        step();
        check_eq("fill_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; tag = 5'd9;
        step();
        check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_ready", {31'd0, in_ready}, 32'd1);
        // Flush with in_ready high: the offered op must be dropped
        tag = 5'd10;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_drop", {31'd0, out_valid}, 32'd0);
        step();
        check_eq("flush_stay", {31'd0, out_valid}, 32'd0);

        // Reset while full
        in_valid = 1'b1; a = 32'h0000_0007; b = 32'd0; op = 3'b000; tag = 5'd4;
        step();
        check_eq("par_data", out_data, 32'h0000_0007);
`ifdef LOGIC_EX_PARITY_EN
        check_eq("par_bit", {31'd0, out_parity}, 32'd1);
`endif
        a = 32'd3; tag = 5'd5;
        step();
        in_valid = 1'b0;
        check_eq("mid_full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_data", out_data, 32'd0);
        check_eq("mid_rst_zero", {31'd0, out_zero}, 32'd1);
        check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd1);
`ifdef LOGIC_EX_PARITY_EN
        check_eq("mid_rst_parity", {31'd0, out_parity}, 32'd0);
`endif
        step();
        check_eq("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
